// File: rtl/arm_mem_pkg.sv
// Shared definitions for the ARM instruction memory path: NOP encoding,
// response error codes and a constant-evaluable ceil(log2) helper.
package arm_mem_pkg;

    // MOV r0, r0 -- returned in place of data for any faulting fetch
    localparam logic [31:0] NOP_ARM = 32'hE1A00000;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2
    } rsp_err_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_rsp_fifo.sv
// Small circular response buffer; clear has priority over push and pop,
// the head is presented combinationally and reads as zero while empty.
module fetch_rsp_fifo
    import arm_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 66,
    localparam int unsigned CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] dout_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i && !clr_i && !rst_i && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// Pipelined instruction fetch memory: fixed-latency in-order reads with
// fault detection, branch flush, output buffering and a program-load port.
module instr_fetch_mem
  import arm_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2,
  parameter              INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [31:0]       rsp_addr,
  output logic [1:0]        rsp_err,
  input  logic              prog_we,
  input  logic [31:0]       prog_addr,
  input  logic [DATA_W-1:0] prog_data
);

  localparam int unsigned OFF_W   = clog2(DATA_W / 8);
  localparam int unsigned IDX_W   = clog2(DEPTH_WORDS);
  localparam int unsigned ENT_W   = DATA_W + 34;
  localparam int unsigned FIFO_D  = LATENCY + 1;
  localparam int unsigned FCNT_W  = clog2(FIFO_D + 1);
  localparam int unsigned OCC_W   = clog2(2 * LATENCY + 2) + 1;
  localparam logic [31:0] OFF_MASK = (32'd1 << OFF_W) - 32'd1;
  localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_ARM);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS] = '{default: '0};

  function automatic logic is_misaligned(input logic [31:0] a);
    return (a & OFF_MASK) != '0;
  endfunction

  function automatic logic is_out_of_range(input logic [31:0] a);
    return (a >> (OFF_W + IDX_W)) != '0;
  endfunction

  logic              xfer;
  logic [IDX_W-1:0]  f_idx;
  rsp_err_e          f_err;
  logic [DATA_W-1:0] f_instr;
  logic [ENT_W-1:0]  f_ent;
  logic              push_vld;
  logic [ENT_W-1:0]  push_ent;
  logic [OCC_W-1:0]  inflight;
  logic              fifo_vld;
  logic [ENT_W-1:0]  fifo_dout;
  logic [FCNT_W-1:0] fifo_cnt;

  assign xfer = req_valid && req_ready;

  // Faulting fetches never touch the array; misalignment wins over range.
  always_comb begin
    f_idx   = req_addr[OFF_W +: IDX_W];
    f_err   = ERR_OK;
    f_instr = mem_q[f_idx];
    if (is_misaligned(req_addr)) begin
      f_err   = ERR_MISALIGN;
      f_instr = NOP_W;
    end else if (is_out_of_range(req_addr)) begin
      f_err   = ERR_RANGE;
      f_instr = NOP_W;
    end
  end

  assign f_ent = {req_addr, f_err, f_instr};

  // LATENCY-1 register stages; the last stage pushes so the response is
  // visible in the FIFO exactly LATENCY cycles after the transfer.
  generate
    if (LATENCY == 1) begin : g_direct
      assign push_vld = xfer;
      assign push_ent = f_ent;
      assign inflight = '0;
    end else begin : g_pipe
      logic [LATENCY-2:0] vld_q;
      logic [ENT_W-1:0]   ent_q [LATENCY-1];

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= xfer;
          for (int unsigned k = 1; k < LATENCY - 1; k++) begin
            vld_q[k] <= vld_q[k-1];
          end
        end
        ent_q[0] <= f_ent;
        for (int unsigned k = 1; k < LATENCY - 1; k++) begin
          ent_q[k] <= ent_q[k-1];
        end
      end

      always_comb begin
        inflight = '0;
        for (int unsigned k = 0; k < LATENCY - 1; k++) begin
          inflight = inflight + OCC_W'(vld_q[k]);
        end
      end

      assign push_vld = vld_q[LATENCY-2];
      assign push_ent = ent_q[LATENCY-2];
    end
  endgenerate

  assign req_ready = !flush && ((inflight + OCC_W'(fifo_cnt)) < OCC_W'(LATENCY + 1));

  // Flush clears the FIFO and beats any result arriving in the same cycle.
  fetch_rsp_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH (ENT_W)
  ) u_rsp_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (flush),
    .push_i  (push_vld),
    .din_i   (push_ent),
    .pop_i   (rsp_ready),
    .valid_o (fifo_vld),
    .dout_o  (fifo_dout),
    .count_o (fifo_cnt)
  );

  assign rsp_valid = fifo_vld;
  assign rsp_addr  = fifo_dout[ENT_W-1 -: 32];
  assign rsp_err   = fifo_dout[DATA_W +: 2];
  assign rsp_instr = fifo_dout[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (prog_we && !is_misaligned(prog_addr) && !is_out_of_range(prog_addr)) begin
      mem_q[prog_addr[OFF_W +: IDX_W]] <= prog_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: the driver queues expected responses,
// an independent monitor compares every response handshake against them.
module tb_instr_fetch_mem;

    localparam int LAT = 2;
    localparam logic [31:0] NOP = 32'hE1A00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_err;
    logic        prog_we = 1'b0;
    logic [31:0] prog_addr = '0;
    logic [31:0] prog_data = '0;

    instr_fetch_mem #(
        .DATA_W      (32),
        .DEPTH_WORDS (64),
        .LATENCY     (LAT),
        .INIT_FILE   ("")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  err;
        logic [31:0] instr;
        bit          lat;
        int          cyc_exp;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [64];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input bit lat, input int c);
        exp_t e;
        e.addr = a;
        e.lat = lat;
        e.cyc_exp = c + LAT;
        if (a[1:0] != 2'b00) begin
            e.err = 2'd1;
            e.instr = NOP;
        end else if (a[31:8] != '0) begin
            e.err = 2'd2;
            e.instr = NOP;
        end else begin
            e.err = 2'd0;
            e.instr = ref_mem[a[7:2]];
        end
        return e;
    endfunction

    // Monitor: compares on every handshake, checks hold-while-stalled.
    initial begin : monitor
        bit          hold;
        logic [31:0] h_instr, h_addr;
        logic [1:0]  h_err;
        exp_t        e;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
                exp_q.delete();
                continue;
            end
            if (hold) begin
                checks++;
                if (!rsp_valid || rsp_instr !== h_instr || rsp_addr !== h_addr || rsp_err !== h_err) begin
                    failures++;
                    $display("FAIL hold_stable actual=%0b/%0h/%0h/%0h required=1/%0h/%0h/%0h",
                             rsp_valid, rsp_instr, rsp_addr, rsp_err, h_instr, h_addr, h_err);
                end
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual=addr %0h instr %0h required=no response",
                             rsp_addr, rsp_instr);
                end else if (rsp_ready) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (rsp_instr !== e.instr || rsp_addr !== e.addr || rsp_err !== e.err) begin
                        failures++;
                        $display("FAIL rsp_data actual=%0h/%0h/%0h required=%0h/%0h/%0h",
                                 rsp_addr, rsp_instr, rsp_err, e.addr, e.instr, e.err);
                    end
                    if (e.lat) chk("rsp_latency_cycle", cyc, e.cyc_exp);
                end
            end
            hold = rsp_valid && !rsp_ready && !flush;
            h_instr = rsp_instr;
            h_addr = rsp_addr;
            h_err = rsp_err;
            if (flush) exp_q.delete();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [31:0] a, input logic [31:0] d);
        prog_we = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we = 1'b0;
        if (a[1:0] == 2'b00 && a[31:8] == '0) ref_mem[a[7:2]] = d;
    endtask

    task automatic fetch(input logic [31:0] a, input bit lat);
        req_valid = 1'b1;
        req_addr = a;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back(model(a, lat, cyc));
                tick();
                req_valid = 1'b0;
                return;
            end
            tick();
        end
        req_valid = 1'b0;
        checks++;
        failures++;
        $display("FAIL fetch_timeout actual=no accept required=accept addr %0h", a);
    endtask

    initial begin : driver
        int          accepts;
        logic [31:0] a;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;

        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_instr", rsp_instr, 0);
        chk("reset_rsp_addr", rsp_addr, 0);
        chk("reset_rsp_err", rsp_err, 0);
        tick();

        for (int i = 0; i < 10; i++) prog(i * 4, 32'hA000_0000 + i * 32'h0001_0001);
        prog(32'h19, 32'h0BAD_0001);
        prog(32'h100, 32'h0BAD_0002);

        fetch(32'h0, 1);
        fetch(32'h4, 1);
        fetch(32'h8, 1);
        repeat (4) tick();

        fetch(32'h18, 0);
        fetch(32'h6, 1);
        fetch(32'h400, 1);
        repeat (4) tick();

        rsp_ready = 1'b0;
        accepts = 0;
        a = 32'hC;
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_addr = a;
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back(model(a, 0, cyc));
                accepts++;
                a = a + 32'd4;
            end
            tick();
        end
        req_valid = 1'b0;
        chk("stall_accepts", accepts, 3);
        @(negedge clk);
        chk("stall_req_ready", req_ready, 0);
        tick();
        rsp_ready = 1'b1;
        repeat (6) tick();

        rsp_ready = 1'b0;
        fetch(32'h1C, 0);
        fetch(32'h24, 0);
        flush = 1'b1;
        req_valid = 1'b1;
        req_addr = 32'h28;
        @(negedge clk);
        chk("flush_req_ready", req_ready, 0);
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("flush_rsp_valid_1", rsp_valid, 0);
        tick();
        @(negedge clk);
        chk("flush_rsp_valid_2", rsp_valid, 0);
        tick();
        rsp_ready = 1'b1;
        fetch(32'h20, 1);
        repeat (4) tick();

        prog_we = 1'b1;
        prog_addr = 32'h14;
        prog_data = 32'hDEADBEEF;
        req_valid = 1'b1;
        req_addr = 32'h14;
        @(negedge clk);
        chk("rbw_req_ready", req_ready, 1);
        if (req_ready) exp_q.push_back(model(32'h14, 1, cyc));
        tick();
        prog_we = 1'b0;
        req_valid = 1'b0;
        ref_mem[5] = 32'hDEADBEEF;
        fetch(32'h14, 1);
        repeat (4) tick();

        rsp_ready = 1'b0;
        fetch(32'h0, 0);
        fetch(32'h4, 0);
        fetch(32'h8, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_rsp_valid", rsp_valid, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        chk("rst_mid_rsp_instr", rsp_instr, 0);
        chk("rst_mid_rsp_addr", rsp_addr, 0);
        chk("rst_mid_rsp_err", rsp_err, 0);
        tick();
        rsp_ready = 1'b1;
        fetch(32'h0, 1);
        fetch(32'h4, 1);
        fetch(32'h8, 1);
        fetch(32'h14, 1);

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) tick();
        chk("drain_pending", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH_WORDS, default 64, number of instruction words stored (power of 2).
REQ-003 SHALL have parameter LATENCY, default 2, request-to-response cycles, legal range 1..4.
REQ-004 SHALL have parameter INIT_FILE, default "", hex image loaded at elaboration; empty means all words zero.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port req_valid, input, 1, fetch request present.
REQ-008 SHALL have port req_ready, output, 1, fetch request accepted when high with req_valid.
REQ-009 SHALL have port req_addr, input, 32, byte address (PC).
REQ-010 SHALL have port flush, input, 1, discard all in-flight and buffered fetches (branch taken).
REQ-011 SHALL have port rsp_valid, output, 1, response present.
REQ-012 SHALL have port rsp_ready, input, 1, consumer accepts response.
REQ-013 SHALL have port rsp_instr, output, DATA_W, fetched instruction, little-endian byte order.
REQ-014 SHALL have port rsp_addr, output, 32, byte address of rsp_instr.
REQ-015 SHALL have port rsp_err, output, 2, 0 ok, 1 misaligned, 2 out of range.
REQ-016 SHALL have ports prog_we input 1, prog_addr input 32, prog_data input DATA_W: word write port for program loading.

Function
REQ-017 SHALL accept a request on any cycle with req_valid && req_ready (transfer).
REQ-018 SHALL assert req_ready = !flush && (inflight + fifo_count) < LATENCY+1, giving one fetch per cycle sustained when rsp_ready is held high.
REQ-019 SHALL present an accepted fetch's response in the output FIFO exactly LATENCY cycles after transfer; rsp_valid rises that cycle if FIFO was empty.
REQ-020 SHALL return responses strictly in request order.
REQ-021 SHALL index word req_addr[log2(DATA_W/8)+:log2(DEPTH_WORDS)].
REQ-022 SHALL, for req_addr with nonzero low byte-offset bits, return rsp_err=1 and rsp_instr=NOP constant (0xE1A00000 for DATA_W=32), no memory access.
REQ-023 SHALL, for word index >= DEPTH_WORDS (upper address bits nonzero), return rsp_err=2 and rsp_instr=NOP; misaligned takes priority over out of range.
REQ-024 SHALL hold rsp_valid, rsp_instr, rsp_addr, rsp_err stable while rsp_valid && !rsp_ready.
REQ-025 SHALL pop the FIFO head on rsp_valid && rsp_ready; simultaneous push and pop leaves count unchanged.
REQ-026 SHALL, on flush, clear all in-flight stages and the FIFO at the next edge; rsp_valid low the following cycle; request presented during flush is not accepted.
REQ-027 SHALL give flush priority over a same-cycle arriving pipeline result (result discarded).
REQ-028 SHALL write prog_data to word prog_addr index on prog_we at clock edge; out-of-range or misaligned prog_addr ignored.
REQ-029 SHALL read old data when a fetch transfer and prog_we target the same word in the same cycle (read-before-write).
REQ-030 SHALL never drop or duplicate an accepted, unflushed fetch under any rsp_ready pattern.

Reset
REQ-031 SHALL, with rst high at an edge, clear inflight stages, FIFO count and pointers; next cycle rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0, req_ready=1.
REQ-032 SHALL NOT modify memory contents on reset; rst mid-operation discards all outstanding fetches, rst overrides flush and transfers.

Structure
REQ-033 SHALL take NOP constant, rsp_err encodings and a clog2 helper from shared package arm_mem_pkg.
REQ-034 SHALL instantiate one sub-module fetch_rsp_fifo (depth LATENCY+1, width DATA_W+34) for output buffering.

Verification
REQ-035 Back-to-back fetch 0x0,0x4,0x8, LATENCY=2, rsp_ready=1 -> responses cycles 2,3,4 with words 0,1,2, rsp_err=0.
REQ-036 Fetch 0x6 and 0x400 (DEPTH_WORDS=64) -> rsp_err=1 then 2, rsp_instr=0xE1A00000 both.
REQ-037 rsp_ready=0 for 10 cycles with continuous req_valid -> req_ready drops after 3 accepts (LATENCY=2), no loss, in-order drain on release.
REQ-038 Flush one cycle after 2 transfers -> no response for either; next fetch 0x20 returns word 8 after LATENCY cycles.
REQ-039 prog_we word 5=0xDEADBEEF with same-cycle fetch 0x14 -> old value; repeat fetch 0x14 -> 0xDEADBEEF.
REQ-040 rst asserted with 3 fetches outstanding -> rsp_valid=0 next cycle, req_ready=1, memory contents unchanged.
